// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch bus (req/addr out, rdata/ready back); master is the fetch stage, slave is the memory
interface if_stage_if;
  logic req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic ready;
  modport master(output req, addr, input rdata, ready);
  modport slave(input req, addr, output rdata, ready);
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage (clk, rst, freeze, branch_taken/branch_addr in; imem bus; IF/ID pc_out/instruction/valid out) with PC, wait-state fetch, freeze buffer and branch flush
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  if_stage_if.master  imem,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state;
  logic [31:0] pc, buf_instr;
  assign imem.req = !rst && !branch_taken && state == FETCH;
  assign imem.addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      buf_instr <= '0;
      state <= FETCH;
      pc_out <= '0;
      instruction <= '0;
      valid <= 1'b0;
    end else if (branch_taken) begin
      pc <= branch_addr;
      buf_instr <= '0;
      state <= FETCH;
      pc_out <= '0;
      instruction <= '0;
      valid <= 1'b0;
    end else if (state == FETCH) begin
      if (imem.ready && !freeze) begin
        pc <= pc + 32'd4;
        pc_out <= pc + 32'd4;
        instruction <= imem.rdata;
        valid <= 1'b1;
      end else if (imem.ready) begin
        buf_instr <= imem.rdata;
        state <= HOLD;
      end else if (!freeze) begin
        valid <= 1'b0;
      end
    end else if (!freeze) begin
      pc <= pc + 32'd4;
      pc_out <= pc + 32'd4;
      instruction <= buf_instr;
      valid <= 1'b1;
      state <= FETCH;
    end
  end
endmodule
